// File: rtl/cache_slot_alloc_if.sv
// Request, grant and release signals between the PEs and the shared-cache slot allocator.
// Grant/address/status fields are driven by the allocator. Request/free fields are driven by the PEs.
interface cache_slot_alloc_if #(
    parameter int Address_Width = 5
);
    logic                     alloc_req_0, alloc_req_1, alloc_req_2, alloc_req_3;
    logic                     alloc_gnt_0, alloc_gnt_1, alloc_gnt_2, alloc_gnt_3;
    logic [Address_Width-1:0] alloc_add_0, alloc_add_1, alloc_add_2, alloc_add_3;
    logic                     free_en_0, free_en_1, free_en_2, free_en_3;
    logic [Address_Width-1:0] free_add_0, free_add_1, free_add_2, free_add_3;
    logic [Address_Width:0]   free_count;
    logic                     full;
    logic                     err;

    modport master (
        output alloc_req_0, alloc_req_1, alloc_req_2, alloc_req_3,
        output free_en_0, free_en_1, free_en_2, free_en_3,
        output free_add_0, free_add_1, free_add_2, free_add_3,
        input  alloc_gnt_0, alloc_gnt_1, alloc_gnt_2, alloc_gnt_3,
        input  alloc_add_0, alloc_add_1, alloc_add_2, alloc_add_3,
        input  free_count, full, err
    );

    modport slave (
        input  alloc_req_0, alloc_req_1, alloc_req_2, alloc_req_3,
        input  free_en_0, free_en_1, free_en_2, free_en_3,
        input  free_add_0, free_add_1, free_add_2, free_add_3,
        output alloc_gnt_0, alloc_gnt_1, alloc_gnt_2, alloc_gnt_3,
        output alloc_add_0, alloc_add_1, alloc_add_2, alloc_add_3,
        output free_count, full, err
    );
endinterface

// File: rtl/cache_slot_alloc.sv
// Dynamic slot allocator for the 4-port shared cache: occupancy bitmap, port-0-first lowest-slot grants.
// Grant/address registered one cycle after the request; no queuing, a PE denied for lack of slots re-requests.
module cache_slot_alloc #(
    parameter int Address_Width = 5,
    parameter int Depth         = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_slot_alloc_if.slave    bus
);
    localparam int NP = 4;
    localparam int NS = 2 ** Address_Width;

    logic [Depth-1:0]         r_busy;
    logic [NP-1:0]            r_gnt;
    logic [Address_Width-1:0] r_add [NP];
    logic [Address_Width:0]   r_count;
    logic                     r_full;
    logic                     r_err;

    logic [NP-1:0]            w_req;
    logic [NP-1:0]            w_fen;
    logic [Address_Width-1:0] w_fadd [NP];
    logic [NS-1:0]            w_avail;
    logic [NS-1:0]            w_set;
    logic [NS-1:0]            w_clr;
    logic [NS-1:0]            w_busy_pad;
    logic [NP-1:0]            w_gnt;
    logic [Address_Width-1:0] w_slot [NP];
    logic                     w_found;
    logic                     w_dup;
    logic                     w_err_now;
    logic [2:0]               w_ngnt;
    logic [2:0]               w_nfree;
    logic [Address_Width:0]   w_count_next;

    assign w_req     = {bus.alloc_req_3, bus.alloc_req_2, bus.alloc_req_1, bus.alloc_req_0};
    assign w_fen     = {bus.free_en_3, bus.free_en_2, bus.free_en_1, bus.free_en_0};
    assign w_fadd[0] = bus.free_add_0;
    assign w_fadd[1] = bus.free_add_1;
    assign w_fadd[2] = bus.free_add_2;
    assign w_fadd[3] = bus.free_add_3;

    // Cascaded priority encoders: each port sees the free set minus slots taken by lower-numbered ports.
    always_comb begin
        w_avail = NS'(~r_busy);
        w_set   = '0;
        w_gnt   = '0;
        w_ngnt  = '0;
        w_found = 1'b0;
        for (int p = 0; p < NP; p++) begin
            w_slot[p] = '0;
            w_found   = 1'b0;
            if (w_req[p]) begin
                for (int s = 0; s < Depth; s++) begin
                    if (!w_found && w_avail[s]) begin
                        w_found   = 1'b1;
                        w_slot[p] = Address_Width'(s);
                    end
                end
            end
            if (w_found) begin
                w_gnt[p]           = 1'b1;
                w_avail[w_slot[p]] = 1'b0;
                w_set[w_slot[p]]   = 1'b1;
                w_ngnt             = w_ngnt + 3'd1;
            end
        end
    end

    // Slots at or above Depth read as not-busy in the padded map, so out-of-range frees fall out as illegal.
    always_comb begin
        w_busy_pad = NS'(r_busy);
        w_clr      = '0;
        w_nfree    = '0;
        w_err_now  = 1'b0;
        w_dup      = 1'b0;
        for (int p = 0; p < NP; p++) begin
            w_dup = 1'b0;
            for (int q = 0; q < p; q++) begin
                if (w_fen[q] && (w_fadd[q] == w_fadd[p])) begin
                    w_dup = 1'b1;
                end
            end
            if (w_fen[p]) begin
                if (!w_busy_pad[w_fadd[p]] || w_dup) begin
                    w_err_now = 1'b1;
                end else begin
                    w_clr[w_fadd[p]] = 1'b1;
                    w_nfree          = w_nfree + 3'd1;
                end
            end
        end
    end

    assign w_count_next = r_count - (Address_Width+1)'(w_ngnt) + (Address_Width+1)'(w_nfree);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_gnt   <= '0;
            for (int p = 0; p < NP; p++) begin
                r_add[p] <= '0;
            end
            r_count <= (Address_Width+1)'(Depth);
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_busy  <= (r_busy | w_set[Depth-1:0]) & ~w_clr[Depth-1:0];
            r_gnt   <= w_gnt;
            for (int p = 0; p < NP; p++) begin
                r_add[p] <= w_slot[p];
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == '0);
            r_err   <= r_err | w_err_now;
        end
    end

    assign bus.alloc_gnt_0 = r_gnt[0];
    assign bus.alloc_gnt_1 = r_gnt[1];
    assign bus.alloc_gnt_2 = r_gnt[2];
    assign bus.alloc_gnt_3 = r_gnt[3];
    assign bus.alloc_add_0 = r_add[0];
    assign bus.alloc_add_1 = r_add[1];
    assign bus.alloc_add_2 = r_add[2];
    assign bus.alloc_add_3 = r_add[3];
    assign bus.free_count  = r_count;
    assign bus.full        = r_full;
    assign bus.err         = r_err;
endmodule
